// File: rtl/vector_feeder.sv
// Vector feeder: streams two int8 operand buffers into an external MAC
// and reports each run's dot product as the accumulator difference.
module vector_feeder #(
  parameter int DEPTH   = 16,
  parameter int CAP_DLY = 1,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic                     wr_sel_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [7:0]               wr_data_i,
  input  logic                     start_i,
  input  logic [$clog2(DEPTH):0]   len_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic [31:0]              result_o,
  output logic                     dsp_enable_o,
  output logic                     dsp_valid_o,
  output logic [7:0]               dsp_input_o,
  output logic [7:0]               dsp_weight_o,
  input  logic [31:0]              dsp_output_i,
  input  logic                     dsp_valid_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = 16;

  typedef enum logic [2:0] {
    IDLE, STREAM, WAIT_V, CAPTURE, DONE
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [AW:0]   len_q;
  logic [AW:0]   len_clip;
  logic [AW-1:0] idx;
  logic [TW-1:0] tmr;
  logic [31:0]   base;
  logic          err;
  logic          last;
  logic          wait_out;
  logic          cap_ok;

  logic [7:0] in_buf [DEPTH];
  logic [7:0] w_buf  [DEPTH];

  logic       busy_d;
  logic       done_d;
  logic       error_d;
  logic       en_d;
  logic       valid_d;
  logic [7:0] in_d;
  logic [7:0] w_d;

  assign len_clip = (len_i > (AW+1)'(DEPTH))
                  ? (AW+1)'(DEPTH) : len_i;
  assign last     = ({1'b0, idx} == len_q - 1'b1);
  assign wait_out = (32'(tmr) + 1 >= TIMEOUT);
  assign cap_ok   = (32'(tmr) + 1 >= CAP_DLY);

  // Buffers are not reset; their contents are don't-care after reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !busy_o) begin
      if (wr_sel_i) w_buf[wr_addr_i]  <= wr_data_i;
      else          in_buf[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start_i)
          state_n = (len_clip == '0) ? DONE : STREAM;
      end
      STREAM: begin
        if (last) state_n = WAIT_V;
      end
      WAIT_V: begin
        if (dsp_valid_i)   state_n = CAPTURE;
        else if (wait_out) state_n = DONE;
      end
      CAPTURE: begin
        if (cap_ok) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The MAC never clears, so each result is raw minus the last raw.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_q    <= '0;
      idx      <= '0;
      tmr      <= '0;
      err      <= 1'b0;
      base     <= '0;
      result_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            len_q <= len_clip;
            idx   <= '0;
            tmr   <= '0;
            err   <= 1'b0;
            if (len_clip == '0) result_o <= '0;
          end
        end
        STREAM: begin
          idx <= idx + 1'b1;
          tmr <= '0;
        end
        WAIT_V: begin
          tmr <= dsp_valid_i ? '0 : tmr + 1'b1;
          if (!dsp_valid_i && wait_out) err <= 1'b1;
        end
        CAPTURE: begin
          tmr <= tmr + 1'b1;
          if (cap_ok) begin
            result_o <= dsp_output_i - base;
            base     <= dsp_output_i;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    busy_d  = (state != IDLE) || start_i;
    done_d  = (state == DONE);
    error_d = (state == DONE) && err;
    en_d    = (state == STREAM) || (state == WAIT_V);
    valid_d = (state == STREAM) && last;
    in_d    = '0;
    w_d     = '0;
    if (state == STREAM) begin
      in_d = in_buf[idx];
      w_d  = w_buf[idx];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
      dsp_enable_o <= 1'b0;
      dsp_valid_o  <= 1'b0;
      dsp_input_o  <= '0;
      dsp_weight_o <= '0;
    end else begin
      busy_o       <= busy_d;
      done_o       <= done_d;
      error_o      <= error_d;
      dsp_enable_o <= en_d;
      dsp_valid_o  <= valid_d;
      dsp_input_o  <= in_d;
      dsp_weight_o <= w_d;
    end
  end

endmodule

// File: tb/tb_vector_feeder.sv
// Bench for vector_feeder: MAC stub, stream monitor and a
// dot-product model tracking the accumulator base across runs.
module tb_vector_feeder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wr_en_i;
  logic        wr_sel_i;
  logic [3:0]  wr_addr_i;
  logic [7:0]  wr_data_i;
  logic        start_i;
  logic [4:0]  len_i;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [31:0] result_o;
  logic        dsp_enable_o;
  logic        dsp_valid_o;
  logic [7:0]  dsp_input_o;
  logic [7:0]  dsp_weight_o;
  logic [31:0] dsp_output_i;
  logic        dsp_valid_i;

  vector_feeder dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wr_en_i(wr_en_i), .wr_sel_i(wr_sel_i),
    .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .start_i(start_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .result_o(result_o),
    .dsp_enable_o(dsp_enable_o), .dsp_valid_o(dsp_valid_o),
    .dsp_input_o(dsp_input_o), .dsp_weight_o(dsp_weight_o),
    .dsp_output_i(dsp_output_i), .dsp_valid_i(dsp_valid_i)
  );

  always #5 clk_i = ~clk_i;

  // MAC stub: one-cycle registered accumulator, resets with the DUT
  logic signed [31:0] acc;
  logic               mac_vi;
  logic               mac_ok = 1'b1;
  logic               stray = 1'b0;
  assign dsp_valid_i = mac_vi | stray;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc          <= 0;
      mac_vi       <= 1'b0;
      dsp_output_i <= 0;
    end else begin
      if (dsp_enable_o) begin
        acc <= acc + $signed(dsp_input_o) * $signed(dsp_weight_o);
        dsp_output_i <= acc + $signed(dsp_input_o) * $signed(dsp_weight_o);
      end
      mac_vi <= dsp_valid_o && mac_ok;
    end
  end

  logic [15:0] el_q [$];
  int          vo_tot = 0;
  int          wait_tot = 0;
  int          zero_bad = 0;
  int          en_tot = 0;
  bit          after_last = 1'b0;

  always @(negedge clk_i) begin
    if (dsp_valid_o) vo_tot++;
    if (dsp_enable_o) begin
      en_tot++;
      if (after_last) begin
        wait_tot++;
        if (dsp_input_o != 0 || dsp_weight_o != 0) zero_bad++;
      end else begin
        el_q.push_back({dsp_input_o, dsp_weight_o});
        if (dsp_valid_o) after_last = 1'b1;
      end
    end
    if (!busy_o) after_last = 1'b0;
  end

  int checks = 0;
  int errors = 0;
  logic signed [7:0] ref_in [16];
  logic signed [7:0] ref_w  [16];
  int mac_total = 0;
  int base_m = 0;
  int last_res = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input bit sel, input int a, input logic [7:0] d);
    wr_en_i = 1'b1; wr_sel_i = sel;
    wr_addr_i = 4'(a); wr_data_i = d;
    @(negedge clk_i);
    wr_en_i = 1'b0;
  endtask

  task automatic load_rand();
    for (int i = 0; i < 16; i++) begin
      ref_in[i] = 8'($urandom);
      ref_w[i]  = 8'($urandom);
      wr(1'b0, i, ref_in[i]);
      wr(1'b1, i, ref_w[i]);
    end
  endtask

  task automatic run(input int len, input bit tmo, input bit poke);
    int L, k, s, q0, v0, w0, e0, exp_res, bad;
    L = (len > 16) ? 16 : len;
    s = 0;
    for (int i = 0; i < L; i++) s += int'(ref_in[i]) * int'(ref_w[i]);
    mac_total += s;
    if (L == 0) exp_res = 0;
    else if (tmo) exp_res = last_res;
    else begin
      exp_res = mac_total - base_m;
      base_m = mac_total;
    end
    last_res = exp_res;
    q0 = el_q.size(); v0 = vo_tot; w0 = wait_tot; e0 = en_tot;
    len_i = 5'(len); start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    k = 1;
    while (!done_o && k < 300) begin
      if (poke && k == 3) begin
        wr_en_i = 1'b1; wr_sel_i = 1'b0; wr_addr_i = 4'd15;
        wr_data_i = ref_in[15] ^ 8'h55;
        start_i = 1'b1; len_i = 5'd1;
      end
      @(negedge clk_i);
      wr_en_i = 1'b0; start_i = 1'b0;
      k++;
    end
    chk("done_seen", 32'(done_o), 32'd1);
    if (L == 0) chk("len0_latency", 32'(k), 32'd2);
    chk("error", 32'(error_o), 32'(tmo));
    chk("result", result_o, 32'(exp_res));
    chk("elem_count", 32'(el_q.size() - q0), 32'(L));
    bad = 0;
    for (int i = 0; i < L && q0 + i < el_q.size(); i++)
      if (el_q[q0 + i] !== {ref_in[i], ref_w[i]}) bad++;
    chk("elem_data", 32'(bad), 32'd0);
    chk("valid_o_count", 32'(vo_tot - v0), 32'(L > 0));
    if (L == 0) chk("len0_no_enable", 32'(en_tot - e0), 32'd0);
    if (tmo) chk("wait_cycles", 32'(wait_tot - w0), 32'(15));
    @(negedge clk_i);
    chk("done_one_cycle", 32'(done_o), 32'd0);
    chk("busy_dropped", 32'(busy_o), 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; wr_en_i = 1'b0; wr_sel_i = 1'b0;
    wr_addr_i = '0; wr_data_i = '0; start_i = 1'b0; len_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_error", 32'(error_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_dsp", {dsp_enable_o, dsp_valid_o, dsp_input_o, dsp_weight_o},
        32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    for (int i = 0; i < 4; i++) begin
      ref_in[i] = 8'(i + 1); ref_w[i] = 8'(i + 5);
      wr(1'b0, i, ref_in[i]); wr(1'b1, i, ref_w[i]);
    end
    run(4, 1'b0, 1'b0);
    chk("dot_70", result_o, 32'd70);

    ref_in[0] = -8'sd1; ref_in[1] = -8'sd1;
    ref_w[0] = 8'sd127; ref_w[1] = -8'sd128;
    for (int i = 0; i < 2; i++) begin
      wr(1'b0, i, ref_in[i]); wr(1'b1, i, ref_w[i]);
    end
    run(2, 1'b0, 1'b0);
    chk("b2b_result_1", result_o, 32'd1);
    chk("mac_raw_71", dsp_output_i, 32'd71);

    run(0, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      load_rand();
      run($urandom_range(1, 16), 1'b0, 1'b0);
    end

    load_rand();
    run(20, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk_i);
      chk("start_ignored", 32'(busy_o), 32'd0);
    end
    run(16, 1'b0, 1'b0);

    mac_ok = 1'b0;
    run(5, 1'b1, 1'b0);
    mac_ok = 1'b1;
    run($urandom_range(1, 16), 1'b0, 1'b0);

    stray = 1'b1;
    @(negedge clk_i);
    stray = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      chk("stray_valid_i", {30'd0, busy_o, done_o}, 32'd0);
    end

    len_i = 5'd16; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy_o), 32'd0);
    chk("async_rst_dsp", {dsp_enable_o, dsp_valid_o, dsp_input_o,
        dsp_weight_o}, 32'd0);
    chk("async_rst_result", result_o, 32'd0);
    repeat (3) begin
      @(negedge clk_i);
      chk("rst_no_done", 32'(done_o), 32'd0);
    end
    rst_i = 1'b0;
    mac_total = 0; base_m = 0; last_res = 0;
    @(negedge clk_i);
    load_rand();
    run($urandom_range(1, 16), 1'b0, 1'b0);

    chk("wait_zero_operands", 32'(zero_bad), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_feeder.md
VECTOR_FEEDER -- requirements
Module: vector_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning vector buffer entries per operand (power of 2, max length).
REQ-002 SHALL have parameter CAP_DLY, default 1, meaning cycles from dsp_valid_i high to a stable dsp_output_i.
REQ-003 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of cycles to wait for dsp_valid_i.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port wr_en_i  input  1  buffer write strobe.
REQ-007 SHALL have port wr_sel_i  input  1  buffer select: 0 = input buffer, 1 = weight buffer.
REQ-008 SHALL have port wr_addr_i  input  log2(DEPTH)  buffer write address.
REQ-009 SHALL have port wr_data_i  input  8  signed write data.
REQ-010 SHALL have port start_i  input  1  one-cycle start request.
REQ-011 SHALL have port len_i  input  log2(DEPTH)+1  vector length, sampled on an accepted start.
REQ-012 SHALL have port busy_o  output  1  high from start acceptance through the done cycle.
REQ-013 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-014 SHALL have port error_o  output  1  timeout flag, valid while done_o is high.
REQ-015 SHALL have port result_o  output  32  signed dot product, held until the next done.
REQ-016 SHALL have port dsp_enable_o  output  1  MAC clock enable.
REQ-017 SHALL have port dsp_valid_o  output  1  tags the last element of a vector.
REQ-018 SHALL have port dsp_input_o  output  8  signed MAC operand A.
REQ-019 SHALL have port dsp_weight_o  output  8  signed MAC operand B.
REQ-020 SHALL have port dsp_output_i  input  32  signed MAC accumulator output.
REQ-021 SHALL have port dsp_valid_i  input  1  delayed MAC valid.

Function
REQ-022 SHALL write wr_data_i to the buffer selected by wr_sel_i at wr_addr_i when wr_en_i is high and busy_o is low; writes while busy_o is high SHALL be ignored.
REQ-023 SHALL implement FSM states IDLE, STREAM, WAIT_V, CAPTURE, DONE.
REQ-024 IDLE: start_i high SHALL accept the start, latch L = min(len_i, DEPTH), clear the element counter, and raise busy_o in the next cycle.
REQ-025 SHALL ignore start_i outside IDLE.
REQ-026 If L = 0, the FSM SHALL go IDLE->DONE with result_o = 0, error_o = 0, and issue no MAC cycles.
REQ-027 STREAM: each cycle SHALL drive dsp_enable_o = 1 with element k from both buffers (k = 0..L-1, one element per cycle, no bubbles).
REQ-028 STREAM: dsp_valid_o SHALL be 1 only with element L-1; after element L-1 is issued the FSM SHALL go to WAIT_V.
REQ-029 WAIT_V: dsp_enable_o SHALL stay 1 so the MAC pipeline drains; dsp_input_o and dsp_weight_o SHALL be 0; dsp_valid_o SHALL be 0.
REQ-030 WAIT_V: dsp_valid_i high SHALL move the FSM to CAPTURE.
REQ-031 WAIT_V: after TIMEOUT cycles without dsp_valid_i, the FSM SHALL go to DONE with error_o = 1 and result_o unchanged.
REQ-032 CAPTURE: SHALL wait CAPTURE_DLY cycles, then sample raw = dsp_output_i.
REQ-033 SHALL set result_o = raw - base (mod 2^32) and then base = raw, because the MAC accumulator never self-clears.
REQ-034 DONE: SHALL assert done_o for exactly one cycle, then return to IDLE.
REQ-035 busy_o SHALL drop in the first IDLE cycle after DONE.
REQ-036 Outside STREAM and WAIT_V, dsp_enable_o, dsp_valid_o, dsp_input_o and dsp_weight_o SHALL all be 0.
REQ-037 A dsp_valid_i pulse outside WAIT_V SHALL be ignored.
REQ-038 All outputs SHALL be registered.

Reset
REQ-039 While rst_i is high, the FSM SHALL be in IDLE, and busy_o, done_o, error_o, result_o, all dsp_* outputs, base and the counters SHALL be 0.
REQ-040 Buffer contents SHALL be unspecified after reset.
REQ-041 Reset asserted mid-operation SHALL abort immediately with no done_o pulse.
REQ-042 The first start after reset SHALL use base = 0.

Verification
REQ-043 Load in = {1,2,3,4}, w = {5,6,7,8}, L = 4, model MAC -> dsp_valid_o only on the 4th element, done_o pulse, result_o = 70, error_o = 0.
REQ-044 Back-to-back runs: second run in = {-1,-1}, w = {127,-128}, L = 2 -> result_o = 1 (difference against base = 70); MAC raw = 71.
REQ-045 L = 0 -> done_o two cycles after start, result_o = 0, no dsp_enable_o asserted.
REQ-046 L = 20 -> clamped to 16 elements streamed; start_i and wr_en_i pulsed while busy -> ignored, buffers unchanged.
REQ-047 MAC stub never returns dsp_valid_i -> done_o with error_o = 1 after 15 WAIT_V cycles; result_o keeps its prior value.
REQ-048 rst_i asserted during STREAM -> all outputs 0 asynchronously, no done_o; a fresh run afterwards is correct with base = 0.
